// File: rtl/leve1_pkg.sv
// leve1_pkg: shared opcodes, CSR map and instruction-classification helpers
// for the LEVE1 decode/operand stage.
package leve1_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
  localparam logic [31:0] INSTR_MRET = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  // Encoded exactly as funct3[1:0] of the Zicsr instructions.
  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_cmd_e;

  typedef struct packed {
    logic [50:0] rsvd_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsvd_10_8;
    logic        mpie;
    logic [2:0]  rsvd_6_4;
    logic        mie;
    logic [2:0]  rsvd_2_0;
  } mstatus_t;

  // Physical slot of an implemented CSR; hit=0 for unimplemented addresses.
  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } csr_slot_t;

  function automatic logic is_mret(input logic [31:0] instr);
    return instr == INSTR_MRET;
  endfunction

  function automatic logic writes_rd(input logic [31:0] instr);
    logic r;
    r = 1'b0;
    case (instr[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
      OP_IMM, OP_IMM32, OP_REG, OP_REG32: r = 1'b1;
      OP_SYSTEM:                          r = (instr[14:12] != 3'b000);
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic reads_csr(input logic [31:0] instr);
    return (instr[6:0] == OP_SYSTEM) && ((instr[14:12] != 3'b000) || is_mret(instr));
  endfunction

  function automatic logic writes_csr(input logic [31:0] instr);
    return (instr[6:0] == OP_SYSTEM) && ((instr[13:12] != 2'b00) || is_mret(instr));
  endfunction

  function automatic logic [11:0] csr_addr(input logic [31:0] instr);
    return is_mret(instr) ? CSR_MSTATUS : instr[31:20];
  endfunction

  function automatic csr_slot_t csr_slot(input logic [11:0] addr);
    csr_slot_t s;
    s = '0;
    case (addr)
      CSR_MSTATUS:  s = '{hit: 1'b1, idx: 3'd0};
      CSR_MIE:      s = '{hit: 1'b1, idx: 3'd1};
      CSR_MTVEC:    s = '{hit: 1'b1, idx: 3'd2};
      CSR_MSCRATCH: s = '{hit: 1'b1, idx: 3'd3};
      CSR_MEPC:     s = '{hit: 1'b1, idx: 3'd4};
      CSR_MCAUSE:   s = '{hit: 1'b1, idx: 3'd5};
      CSR_MTVAL:    s = '{hit: 1'b1, idx: 3'd6};
      CSR_MIP:      s = '{hit: 1'b1, idx: 3'd7};
      default:      s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/leve1_id_if.sv
// leve1_id_if: fetch-side, execute/writeback-side and output bundle of the
// decode stage. slave = the decode stage, master = its environment.
interface leve1_id_if #(
  parameter int unsigned XLEN = 64
);
  logic            IVALID;
  logic            IREADY;
  logic [XLEN-1:0] IPC;
  logic [31:0]     IINSTR;
  logic            IFLASH;
  logic [XLEN-1:0] EX_FWD_RD;
  logic            WB_VALID;
  logic [31:0]     WB_INSTR;
  logic            WB_WE;
  logic [XLEN-1:0] WB_RD;
  logic [XLEN-1:0] WB_CSRD;
  logic            OVALID;
  logic [XLEN-1:0] OPC;
  logic [31:0]     OINSTR;
  logic [XLEN-1:0] ORS1;
  logic [XLEN-1:0] ORS2;
  logic [XLEN-1:0] OCSR;

  modport master (
    output IVALID, IPC, IINSTR, IFLASH, EX_FWD_RD,
           WB_VALID, WB_INSTR, WB_WE, WB_RD, WB_CSRD,
    input  IREADY, OVALID, OPC, OINSTR, ORS1, ORS2, OCSR
  );

  modport slave (
    input  IVALID, IPC, IINSTR, IFLASH, EX_FWD_RD,
           WB_VALID, WB_INSTR, WB_WE, WB_RD, WB_CSRD,
    output IREADY, OVALID, OPC, OINSTR, ORS1, ORS2, OCSR
  );
endinterface

// File: rtl/leve1_regfile.sv
// leve1_regfile: 32 x XLEN integer register file, two combinational read
// ports with write-through from the single write port; x0 reads as zero.
module leve1_regfile #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [32];

  // Register storage; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports with same-cycle write-through.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
    if (raddr2 != '0) rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/leve1_id.sv
// leve1_id: LEVE1 decode/operand stage. Holds the integer register file and
// the machine CSR file, resolves rs1/rs2/CSR operands against execute
// (forwarding) and writeback (write-through), and stalls one cycle on CSR
// hazards. Macro LEVE1_FWD_EN enables EX forwarding; without it an EX match
// stalls one cycle and the operand arrives through write-through instead.
module leve1_id
  import leve1_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CSR_N = 8
) (
  input logic       CLK,
  input logic       RSTn,
  leve1_id_if.slave bus
);

  logic [4:0]      rs1_idx, rs2_idx, ex_rd, wb_rd_idx;
  logic [XLEN-1:0] rf_rs1, rf_rs2, rs1_val, rs2_val;
  logic            rf_we;
  logic            ex_wr, fwd1, fwd2, raw_stall, csr_hazard, stall, accept;
  logic [11:0]     id_csr_addr, wb_csr_addr;
  csr_slot_t       id_slot, wb_slot;
  logic            wb_csr_en;
  csr_cmd_e        wb_cmd;
  logic [XLEN-1:0] csr_old, csr_new, csr_val;
  logic [XLEN-1:0] csr_q [CSR_N];

  assign rs1_idx   = bus.IINSTR[19:15];
  assign rs2_idx   = bus.IINSTR[24:20];
  assign ex_rd     = bus.OINSTR[11:7];
  assign wb_rd_idx = bus.WB_INSTR[11:7];
  assign rf_we     = bus.WB_VALID && bus.WB_WE && (wb_rd_idx != '0);

  leve1_regfile #(.XLEN(XLEN)) u_regfile (
    .clk    (CLK),
    .rst_n  (RSTn),
    .we     (rf_we),
    .waddr  (wb_rd_idx),
    .wdata  (bus.WB_RD),
    .raddr1 (rs1_idx),
    .rdata1 (rf_rs1),
    .raddr2 (rs2_idx),
    .rdata2 (rf_rs2)
  );

  // Operand resolution: EX forward over regfile (which already includes WB write-through).
  always_comb begin
    ex_wr = bus.OVALID && writes_rd(bus.OINSTR) && (ex_rd != '0);
    fwd1  = ex_wr && (ex_rd == rs1_idx);
    fwd2  = ex_wr && (ex_rd == rs2_idx);
`ifdef LEVE1_FWD_EN
    raw_stall = 1'b0;
    rs1_val   = fwd1 ? bus.EX_FWD_RD : rf_rs1;
    rs2_val   = fwd2 ? bus.EX_FWD_RD : rf_rs2;
`else
    raw_stall = fwd1 || fwd2;
    rs1_val   = rf_rs1;
    rs2_val   = rf_rs2;
`endif
  end

  // CSR writeback command, post-op value and read port with write-through.
  always_comb begin
    id_csr_addr = csr_addr(bus.IINSTR);
    wb_csr_addr = csr_addr(bus.WB_INSTR);
    id_slot     = csr_slot(id_csr_addr);
    wb_slot     = csr_slot(wb_csr_addr);
    wb_csr_en   = bus.WB_VALID && bus.WB_WE && (bus.WB_INSTR[6:0] == OP_SYSTEM) && wb_slot.hit;
    wb_cmd      = is_mret(bus.WB_INSTR) ? CSR_WRITE : csr_cmd_e'(bus.WB_INSTR[13:12]);
    csr_old     = csr_q[wb_slot.idx];
    csr_new     = csr_old;
    case (wb_cmd)
      CSR_WRITE: csr_new = bus.WB_CSRD;
      CSR_SET:   csr_new = csr_old | bus.WB_CSRD;
      CSR_CLEAR: csr_new = csr_old & ~bus.WB_CSRD;
      default:   csr_new = csr_old;
    endcase
    csr_val = '0;
    if (id_slot.hit) begin
      csr_val = (wb_csr_en && (wb_slot.idx == id_slot.idx)) ? csr_new : csr_q[id_slot.idx];
    end
  end

  // Hazard detection and handshake; a flush drops the instruction even when stalled.
  always_comb begin
    csr_hazard = reads_csr(bus.IINSTR) && bus.OVALID && writes_csr(bus.OINSTR)
                 && (id_csr_addr == csr_addr(bus.OINSTR));
    stall      = csr_hazard || raw_stall;
    accept     = bus.IVALID && !stall && !bus.IFLASH;
  end

  assign bus.IREADY = !stall;

  // CSR file state.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int unsigned i = 0; i < CSR_N; i++) csr_q[i] <= '0;
    end else if (wb_csr_en) begin
      csr_q[wb_slot.idx] <= csr_new;
    end
  end

  // ID/EX pipeline register; bubbles only clear OVALID and hold the payload.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      bus.OVALID <= 1'b0;
      bus.OPC    <= '0;
      bus.OINSTR <= INSTR_NOP;
      bus.ORS1   <= '0;
      bus.ORS2   <= '0;
      bus.OCSR   <= '0;
    end else begin
      bus.OVALID <= accept;
      if (accept) begin
        bus.OPC    <= bus.IPC;
        bus.OINSTR <= bus.IINSTR;
        bus.ORS1   <= rs1_val;
        bus.ORS2   <= rs2_val;
        bus.OCSR   <= csr_val;
      end
    end
  end

endmodule

// File: tb/tb_leve1_id.sv
// tb_leve1_id: directed bench for leve1_id with a scoreboard; stimulus pushes
// the expected execute-stage payload, a negedge monitor pops it on OVALID.
module tb_leve1_id;

  localparam logic [63:0] Z = '0;

  logic CLK = 1'b0;
  logic RSTn;

  leve1_id_if #(.XLEN(64)) bus ();

  leve1_id #(.XLEN(64), .CSR_N(8)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] csr;
  } exp_t;

  exp_t        sb [$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented output must match the oldest expected entry.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (bus.OVALID === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ovalid: got OVALID=1 at pc %h, expected no output", bus.OPC);
      end else begin
        e = sb.pop_front();
        chk("opc",    bus.OPC, e.pc);
        chk("oinstr", 64'(bus.OINSTR), 64'(e.instr));
        chk("ors1",   bus.ORS1, e.rs1);
        chk("ors2",   bus.ORS2, e.rs2);
        chk("ocsr",   bus.OCSR, e.csr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wb(input logic v, input logic [31:0] instr, input logic [63:0] rd,
                    input logic [63:0] csrd);
    bus.WB_VALID = v;
    bus.WB_WE    = v;
    bus.WB_INSTR = instr;
    bus.WB_RD    = rd;
    bus.WB_CSRD  = csrd;
  endtask

  task automatic fetch(input logic v, input logic [63:0] pc, input logic [31:0] instr);
    bus.IVALID = v;
    bus.IPC    = pc;
    bus.IINSTR = instr;
  endtask

  task automatic idle();
    bus.IVALID = 1'b0;
  endtask

  // Present an instruction that must be accepted this cycle and queue its result.
  task automatic issue(input logic [63:0] pc, input logic [31:0] instr,
                       input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] c);
    fetch(1'b1, pc, instr);
    #1;
    chk("iready_accept", 64'(bus.IREADY), 64'd1);
    sb.push_back('{pc, instr, r1, r2, c});
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_ovalid"}, 64'(bus.OVALID), Z);
    chk({tag, "_opc"},    bus.OPC, Z);
    chk({tag, "_oinstr"}, 64'(bus.OINSTR), 64'h13);
    chk({tag, "_ors1"},   bus.ORS1, Z);
    chk({tag, "_ors2"},   bus.ORS2, Z);
    chk({tag, "_ocsr"},   bus.OCSR, Z);
    chk({tag, "_iready"}, 64'(bus.IREADY), 64'd1);
  endtask

  initial begin
    RSTn          = 1'b0;
    bus.IFLASH    = 1'b0;
    bus.EX_FWD_RD = Z;
    fetch(1'b0, Z, 32'h00000013);
    wb(1'b0, 32'h0, Z, Z);
    tick();
    tick();
    reset_chk("reset");
    RSTn = 1'b1;
    tick();

    // ADDI x1,x0,5 then ADD x2,x1,x1 (older WB to x1 in flight must lose to EX)
    issue(64'h100, 32'h00500093, Z, Z, Z);
    tick();
    bus.EX_FWD_RD = 64'h5;
    wb(1'b1, 32'h00000093, 64'h77, Z);
`ifdef LEVE1_FWD_EN
    issue(64'h104, 32'h00108133, 64'h5, 64'h5, Z);
    tick();
    wb(1'b1, 32'h00500093, 64'h5, Z);
    idle();
    tick();
`else
    fetch(1'b1, 64'h104, 32'h00108133);
    #1;
    chk("raw_stall_iready", 64'(bus.IREADY), Z);
    tick();
    chk("raw_bubble_ovalid", 64'(bus.OVALID), Z);
    wb(1'b1, 32'h00500093, 64'h5, Z);
    issue(64'h104, 32'h00108133, 64'h5, 64'h5, Z);
    tick();
`endif
    wb(1'b0, 32'h0, Z, Z);
    idle();
    tick();

    // WB writes x3 while ID reads x3, then a plain regfile read
    wb(1'b1, 32'h00000193, 64'hDEAD, Z);
    issue(64'h108, 32'h00018333, 64'hDEAD, Z, Z);
    tick();
    wb(1'b0, 32'h0, Z, Z);
    issue(64'h10C, 32'h00118333, 64'hDEAD, 64'h5, Z);
    tick();
    idle();
    tick();

    // x0: WB write discarded, EX writing x0 never forwards
    wb(1'b1, 32'h00000013, 64'hFF, Z);
    issue(64'h110, 32'h00000033, Z, Z, Z);
    tick();
    wb(1'b0, 32'h0, Z, Z);
    bus.EX_FWD_RD = 64'h5A;
    issue(64'h114, 32'h00000433, Z, Z, Z);
    tick();
    idle();
    tick();

    // x4 = 0x55; CSRRW mscratch,x4 then CSRRS x5,mscratch,x0
    wb(1'b1, 32'h00000213, 64'h55, Z);
    tick();
    wb(1'b0, 32'h0, Z, Z);
    issue(64'h118, 32'h34021073, 64'h55, Z, Z);
    tick();
    fetch(1'b1, 64'h11C, 32'h340022F3);
    #1;
    chk("csr_stall_iready", 64'(bus.IREADY), Z);
    tick();
    chk("csr_bubble_ovalid", 64'(bus.OVALID), Z);
    wb(1'b1, 32'h34021073, Z, 64'h55);
    issue(64'h11C, 32'h340022F3, Z, Z, 64'h55);
    tick();
    wb(1'b0, 32'h0, Z, Z);
    issue(64'h120, 32'h00000013, Z, Z, Z);
    tick();
    issue(64'h124, 32'h340022F3, Z, Z, 64'h55);
    tick();
    idle();
    tick();

    // mstatus: write 0x88, CSRRC 0x08 seen same cycle, then MRET writes 0x1880
    wb(1'b1, 32'h30001073, Z, 64'h88);
    tick();
    wb(1'b1, 32'h30003073, Z, 64'h08);
    issue(64'h128, 32'h300023F3, Z, Z, 64'h80);
    tick();
    wb(1'b1, 32'h30200073, Z, 64'h1880);
    idle();
    tick();
    wb(1'b0, 32'h0, Z, Z);
    issue(64'h12C, 32'h300023F3, Z, Z, 64'h1880);
    tick();
    idle();
    tick();

    // Unimplemented CSR: write ignored, read returns 0
    wb(1'b1, 32'h7C001073, Z, 64'hABC);
    issue(64'h130, 32'h7C002073, Z, Z, Z);
    tick();
    wb(1'b0, 32'h0, Z, Z);
    idle();
    tick();

    // Flush during a valid accept, then a normal accept
    bus.IFLASH = 1'b1;
    fetch(1'b1, 64'h134, 32'h00500093);
    tick();
    bus.IFLASH = 1'b0;
    chk("flush_ovalid", 64'(bus.OVALID), Z);
    issue(64'h138, 32'h00118333, 64'hDEAD, 64'h5, Z);
    tick();
    idle();
    tick();

    // Flush together with a CSR stall: bubble, instruction dropped
    issue(64'h13C, 32'h34021073, 64'h55, Z, 64'h55);
    tick();
    bus.IFLASH = 1'b1;
    fetch(1'b1, 64'h140, 32'h340022F3);
    #1;
    chk("flush_stall_iready", 64'(bus.IREADY), Z);
    tick();
    bus.IFLASH = 1'b0;
    chk("flush_stall_ovalid", 64'(bus.OVALID), Z);
    idle();
    tick();

    // Reset asserted mid-stall
    issue(64'h144, 32'h34021073, 64'h55, Z, 64'h55);
    tick();
    fetch(1'b1, 64'h148, 32'h340022F3);
    #1;
    chk("rst_stall_iready", 64'(bus.IREADY), Z);
    RSTn = 1'b0;
    tick();
    reset_chk("midrst");
    idle();
    RSTn = 1'b1;
    tick();
    chk("post_rst_iready", 64'(bus.IREADY), 64'd1);
    // Register file and CSR file were cleared: x4 and mscratch read 0
    issue(64'h14C, 32'h340222F3, Z, Z, Z);
    tick();
    idle();
    tick();
    tick();
    chk("scoreboard_drain", 64'(sb.size()), Z);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/leve1_id.md
# leve1_id

Decode/operand stage of the LEVE1 pipeline, between fetch and the execute stage. It holds the integer register file and the machine CSR file and reads rs1, rs2 and the addressed CSR for each fetched instruction. Operands are resolved against the instruction currently in execute (forwarding) and the instruction currently writing back (write-through), then registered into the execute stage. It also applies execute-stage writebacks to both files and inserts a bubble on hazards that cannot be forwarded.

## Interface
- XLEN, 64, datapath width
- CSR_N, 8, number of implemented machine CSRs
- CLK  in  1  clock
- RSTn  in  1  reset; one clock; reset is synchronous and active-low
- IVALID  in  1  fetch has an instruction
- IREADY  out  1  stage accepts the instruction this cycle
- IPC  in  XLEN  fetch PC
- IINSTR  in  32  fetch instruction
- IFLASH  in  1  execute redirect; the incoming instruction is wrong-path
- EX_FWD_RD  in  XLEN  execute-stage combinational rd result
- WB_VALID  in  1  execute output valid
- WB_INSTR  in  32  instruction being written back
- WB_WE  in  1  rd/CSR write enable
- WB_RD  in  XLEN  rd write data
- WB_CSRD  in  XLEN  CSR operand or new mstatus (MRET)
- OVALID  out  1  to execute
- OPC  out  XLEN  to execute
- OINSTR  out  32  to execute
- ORS1, ORS2  out  XLEN  resolved operands
- OCSR  out  XLEN  resolved CSR read value

## Operation
- Accept when IVALID && IREADY. OVALID, OPC, OINSTR, ORS1, ORS2 and OCSR load at the next edge.
- IFLASH=1: the next OVALID=0. The flush overrides any stall.
- Source indices are IINSTR[19:15] and IINSTR[24:20]. Index x0 reads 0 unconditionally.
- Operand priority, highest first:
  - EX forward: OVALID && OINSTR writes rd && rd==src && rd!=0 → EX_FWD_RD.
  - WB write-through: WB_VALID && WB_WE && WB_INSTR[11:7]==src → WB_RD.
  - Register file.
- CSR address is IINSTR[31:20]. MRET reads/writes mstatus (0x300).
- Implemented CSRs: mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip. Other addresses read 0, and writes to them are ignored.
- CSR writeback on WB_VALID && WB_WE && SYSTEM opcode, by WB_INSTR funct3[1:0]:
  - 01: write.
  - 10: old | WB_CSRD.
  - 11: old & ~WB_CSRD.
  - MRET: mstatus := WB_CSRD.
  - An equal-cycle CSR read sees the post-op value (write-through).
- CSR hazard: the ID instruction reads CSR X while the EX instruction (OVALID) writes CSR X → IREADY=0 and a bubble (OVALID=0) is inserted. This hazard lasts exactly one cycle.
- Register file writeback: WB_VALID && WB_WE && rd!=0 → regfile[rd] := WB_RD.

## Timing
- Reset values: OVALID 0, OPC 0, OINSTR 32'h00000013, ORS1/ORS2/OCSR 0, IREADY 1. All x1–x31 and all CSRs are cleared to 0.
- Latency: accepted instruction → OVALID one cycle later.
- IREADY is combinational from IINSTR/OINSTR. Fetch holds IPC/IINSTR stable while IREADY=0.
- Reset asserted mid-stall clears the pipeline register. IREADY returns to 1 in the cycle after reset deasserts.
- Flush and stall in the same cycle: the bubble is inserted and the instruction is dropped.
- Simultaneous EX match and WB match: EX wins.
- WB write to x0 is discarded.

## Configuration
- LEVE1_FWD_EN defined: EX forwarding is active as above.
- LEVE1_FWD_EN undefined: an EX-forward match instead stalls one cycle (IREADY=0, bubble). The operand is then taken through WB write-through.

## Structure
- Package leve1_pkg holds:
  - Opcode constants.
  - CSR addresses.
  - CSR command encodings (CSR_NONE/WRITE/SET/CLEAR).
  - mstatus_t.
  - Functions writes_rd(instr), reads_csr(instr), writes_csr(instr) and csr_addr(instr).
- Sub-module leve1_regfile: 32×XLEN, two combinational read ports, one write port, write-through, x0 hardwired to zero.
- CSR file, hazard logic and pipeline register live in leve1_id.

## Test plan
- Back-to-back ADDI x1,x0,5 then ADD x2,x1,x1 → second ORS1=ORS2=5 with no stall (FWD_EN). Without FWD_EN, one bubble is inserted and then the operands are 5.
- WB writes x3=0xDEAD while ID reads x3 → ORS1=0xDEAD in the same cycle.
- CSRRW mscratch,x4 (x4=0x55) followed by CSRRS x5,mscratch,x0 → IREADY low for one cycle, bubble inserted, then OCSR=0x55.
- CSRRC on mstatus=0x88 with WB_CSRD=0x08 → mstatus=0x80. MRET writeback of 0x1880 → mstatus=0x1880.
- IFLASH during a valid accept → next OVALID=0. The following instruction is accepted normally.
- Write x0 via WB with data 0xFF → subsequent read of x0 returns 0. Assert RSTn=0 mid-stall → all outputs take their reset values next edge.
